// File: rtl/crc32_nword_frame.sv
// crc32_nword_frame: streaming IEEE 802.3 CRC-32 over NUM_WORDS x 64-bit beats,
// with per-frame restart, byte-granular last beat, result strobe and residue check.
module crc32_nword_frame #(
    parameter int TARGET_CHIP = 2,
    parameter int NUM_WORDS   = 2,
    parameter int EW          = $clog2(8*NUM_WORDS)
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     din_valid,
    input  logic                     din_last,
    input  logic [EW-1:0]            din_empty,
    input  logic [64*NUM_WORDS-1:0]  din,
    output logic                     crc_valid,
    output logic [31:0]              crc,
    output logic                     crc_ok
);
    localparam int BYTES = 8*NUM_WORDS;
    localparam int EW1 = EW + 1;
    localparam logic [EW-1:0] EMAX = EW'(BYTES-1);

    function automatic logic [31:0] step_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    function automatic logic [31:0] zadv(input logic [31:0] c, input int n);
        logic [31:0] r;
        r = c;
        for (int j = 0; j < n; j++) r = step_byte(r, 8'h00);
        return r;
    endfunction

    function automatic logic [31:0] sig_word(input logic [63:0] d, input int zb);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r = step_byte(r, d[63-8*j -: 8]);
        return zadv(r, zb);
    endfunction

    logic [EW-1:0]           e_in;
    logic [64*NUM_WORDS-1:0] din_al;
    logic [31:0]             sig_d [NUM_WORDS];
    logic [31:0]             sig_q [NUM_WORDS];
    logic [31:0]             adv [BYTES];
    logic [31:0]             adv_sel, sig_x, nxt;
    logic [31:0]             run_q, res_q;
    logic [EW-1:0]           e1_q;
    logic                    v1_q, l1_q, v2_q;

    assign e_in = !din_last ? '0 : ({1'b0, din_empty} >= EW1'(BYTES)) ? EMAX : din_empty;
    // Right-align the used bytes: leading zero bytes leave a zero-seeded signature unchanged.
    assign din_al = din >> {e_in, 3'b000};

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_sig
        assign sig_d[g] = sig_word(din_al[64*(NUM_WORDS-g)-1 -: 64], 8*(NUM_WORDS-1-g));
    end

    for (genvar k = 0; k < BYTES; k++) begin : g_adv
        assign adv[k] = zadv(run_q, BYTES-k);
    end

    if (TARGET_CHIP >= 2) begin : g_bin
        assign adv_sel = adv[e1_q];
    end else begin : g_oh
        always_comb begin
            adv_sel = '0;
            for (int k = 0; k < BYTES; k++) adv_sel |= (e1_q == EW'(k)) ? adv[k] : '0;
        end
    end

    always_comb begin
        sig_x = '0;
        for (int i = 0; i < NUM_WORDS; i++) sig_x ^= sig_q[i];
    end

    assign nxt = adv_sel ^ sig_x;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            v1_q      <= 1'b0;
            l1_q      <= 1'b0;
            e1_q      <= '0;
            sig_q     <= '{default: '0};
            run_q     <= '1;
            res_q     <= '0;
            v2_q      <= 1'b0;
            crc_valid <= 1'b0;
            crc       <= '0;
            crc_ok    <= 1'b0;
        end else begin
            v1_q <= din_valid;
            l1_q <= din_valid & din_last;
            if (din_valid) begin
                e1_q  <= e_in;
                sig_q <= sig_d;
            end
            if (v1_q) run_q <= l1_q ? '1 : nxt;
            if (v1_q & l1_q) res_q <= nxt;
            v2_q      <= v1_q & l1_q;
            crc_valid <= v2_q;
            if (v2_q) begin
                crc    <= ~res_q;
                crc_ok <= (~res_q == 32'h2144DF1C);
            end
        end
    end
endmodule

// File: tb/tb_crc32_nword_frame.sv
// tb_crc32_nword_frame: drives 1..4-word instances with directed and random frames,
// checking every strobe against a byte-wise software CRC-32 model.
module tb_crc32_nword_frame;
    typedef logic [7:0] bq_t [$];
    typedef struct { int k; int c; logic [31:0] crc; logic ok; } ev_t;
    localparam logic [31:0] RES = 32'h2144DF1C;

    logic         clk = 1'b0, arst = 1'b1, last = 1'b0;
    logic [3:0]   vld = '0;
    logic [4:0]   emp = '0;
    logic [255:0] dat = '0;
    logic [3:0]   cv, ok;
    logic [31:0]  cr [4];
    int           cyc = 0, total = 0, bad = 0;
    ev_t          evq[$], exq[$];
    logic [31:0]  last_crc;
    logic         last_ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar n = 1; n <= 4; n++) begin : g_dut
        crc32_nword_frame #(.NUM_WORDS(n)) u_dut (
            .clk(clk), .arst(arst), .din_valid(vld[n-1]), .din_last(last),
            .din_empty(emp[$clog2(8*n)-1:0]), .din(dat[64*n-1:0]),
            .crc_valid(cv[n-1]), .crc(cr[n-1]), .crc_ok(ok[n-1]));
    end

    always @(negedge clk)
        for (int i = 0; i < 4; i++) if (cv[i] === 1'b1) evq.push_back('{i + 1, cyc, cr[i], ok[i]});

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] ref_crc(input bq_t q);
        logic [31:0] c;
        c = '1;
        foreach (q[i]) begin
            c ^= {24'h0, q[i]};
            repeat (8) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return ~c;
    endfunction

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic bq_t rnd_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input int nw, input bq_t q, input int gap_pct, input int force_emp);
        int bb, nb, e, used;
        bq_t sent;
        bb = 8*nw;
        nb = (q.size() + bb - 1) / bb;
        for (int bt = 0; bt < nb; bt++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                vld = '0; dat = rnd(); last = 1'($urandom_range(1)); emp = 5'($urandom);
                @(posedge clk); #1;
            end
            dat = rnd();
            for (int j = 0; j < bb; j++)
                if (bt*bb + j < q.size()) dat[64*nw-1-8*j -: 8] = q[bt*bb + j];
            last = (bt == nb - 1);
            e = (force_emp >= 0) ? force_emp : nb*bb - q.size();
            emp = last ? 5'(e) : 5'($urandom);
            used = last ? bb - ((e > bb - 1) ? bb - 1 : e) : bb;
            for (int j = 0; j < used; j++) sent.push_back(dat[64*nw-1-8*j -: 8]);
            vld = 4'(1 << (nw - 1));
            if (last) exq.push_back('{nw, cyc + 3, ref_crc(sent), ref_crc(sent) == RES});
            @(posedge clk); #1;
        end
        vld = '0;
    endtask

    task automatic drain(input string tag);
        ev_t e, x;
        last_crc = 'x;
        last_ok = 1'bx;
        repeat (8) @(posedge clk);
        #1;
        chk({tag, ":count"}, evq.size(), exq.size());
        while (evq.size() > 0 && exq.size() > 0) begin
            e = evq.pop_front();
            x = exq.pop_front();
            chk({tag, ":width"}, e.k, x.k);
            chk({tag, ":cycle"}, e.c, x.c);
            chk({tag, ":crc"}, e.crc, x.crc);
            chk({tag, ":ok"}, 32'(e.ok), 32'(x.ok));
            last_crc = e.crc;
            last_ok = e.ok;
        end
        evq.delete();
        exq.delete();
    endtask

    initial begin
        bq_t q9, p, f, t;
        logic [31:0] c;
        int ws[3] = '{1, 2, 4};
        int idx;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_valid", 32'(cv[i]), 0);
            chk("rst_crc", cr[i], 0);
            chk("rst_ok", 32'(ok[i]), 0);
        end
        arst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) q9.push_back(8'(49 + i));
        for (int n = 1; n <= 4; n++) begin
            send(n, q9, 0, -1);
            drain("check9");
            chk("check9_crc", last_crc, 32'hCBF43926);
            chk("check9_ok", 32'(last_ok), 0);
        end

        foreach (ws[w]) begin
            p = rnd_bytes(60);
            c = ref_crc(p);
            f = p;
            for (int b = 0; b < 4; b++) f.push_back(c[8*b +: 8]);
            send(ws[w], f, 0, -1);
            drain("eth_good");
            chk("eth_good_ok", 32'(last_ok), 1);
            t = f;
            idx = $urandom_range(63);
            t[idx] = t[idx] ^ 8'(1 << $urandom_range(7));
            send(ws[w], t, 0, -1);
            drain("eth_flip");
            chk("eth_flip_ok", 32'(last_ok), 0);
        end

        p = rnd_bytes(60);
        send(2, p, 40, -1);
        drain("gaps");
        chk("gaps_crc", last_crc, ref_crc(p));
        send(2, p, 0, -1);
        drain("nogaps");
        chk("nogaps_crc", last_crc, ref_crc(p));

        for (int n = 2; n <= 3; n++) begin
            send(n, rnd_bytes(1), 0, -1);
            send(n, rnd_bytes(17), 0, -1);
            send(n, rnd_bytes(16), 0, -1);
            drain("b2b");
        end

        p = rnd_bytes(5);
        t = {p[0]};
        send(3, p, 0, 27);
        drain("oor27");
        chk("oor27_crc", last_crc, ref_crc(t));
        send(3, p, 0, 24);
        drain("oor24");
        chk("oor24_crc", last_crc, ref_crc(t));

        dat = rnd(); last = 1'b0; vld = 4'b0010;
        @(posedge clk); #1;
        dat = rnd(); arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0; vld = '0;
        chk("arst_valid", 32'(cv[1]), 0);
        chk("arst_crc", cr[1], 0);
        @(posedge clk); #1;
        send(2, q9, 0, -1);
        drain("after_arst");
        chk("after_arst_crc", last_crc, 32'hCBF43926);

        for (int d = 0; d < 2; d++) begin
            send(2, q9, 0, -1);
            repeat (d) begin @(posedge clk); #1; end
            arst = 1'b1;
            @(posedge clk); #1;
            arst = 1'b0;
            void'(exq.pop_back());
            drain("inflight_drop");
        end

        for (int r = 0; r < 20; r++)
            send($urandom_range(1, 4), rnd_bytes($urandom_range(1, 70)), 20, -1);
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
